uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Serial UART receiver (8N1, LSB first) with a small byte FIFO. It is the producing end of the
//   core's receive interface: it drives rx_data/rx_eff into the data-memory peripheral
//   (UART_RXD/RX_EFF) and consumes its read strobe (RX_READ). It sits between the board RX pin
//   and the CPU core, in the core's clock domain.
// PARAMETERS
//   CLKS_PER_BIT  5208  clk cycles per serial bit (50 MHz / 9600 baud); must be >= 4
//   FIFO_AW       2     log2 of FIFO depth (2 -> 4 entries)
// PORTS
//   clk        in   1  system clock; all logic on the rising edge
//   reset      in   1  synchronous, active-high reset
//   uart_rx    in   1  asynchronous serial input pin; idles high
//   rx_data    out  8  byte at the FIFO head; valid only while rx_eff=1
//   rx_eff     out  1  FIFO non-empty (byte available to core)
//   rx_read    in   1  pop strobe from core; one entry popped per cycle with rx_read&rx_eff
//   frame_err  out  1  sticky: stop bit sampled low
//   overrun    out  1  sticky: byte received while FIFO full (byte dropped)
//   err_clr    in   1  clears frame_err and overrun (set in the same cycle wins)
//   rx_busy    out  1  receiver FSM not IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, bit counter/baud counter=0, FIFO empty. Outputs: rx_data=0, rx_eff=0,
//   frame_err=0, overrun=0, rx_busy=0. Both sync flops preset to 1.
// - Input sync: uart_rx passes through 2 flops (rxs); all FSM decisions use rxs only.
// - FSM, with baud counter bc:
//   IDLE:  rxs==0 -> START, bc=0.
//   START: at bc==CLKS_PER_BIT/2-1 sample rxs: 0 -> DATA, bc=0, bit index=0; 1 -> IDLE
//          (glitch rejected, nothing logged).
//   DATA:  at bc==CLKS_PER_BIT-1 shift rxs into bit[index] (LSB first), bc=0; after bit 7 -> STOP.
//   STOP:  at bc==CLKS_PER_BIT-1 sample rxs:
//          1 -> push byte (if FIFO full: drop, set overrun);
//          0 -> discard, set frame_err. Then -> IDLE immediately (mid-stop-bit), allowing a
//          next start edge to be caught.
// - Data sampling is mid-bit; bc is free of drift accumulation, restarted at every edge-qualified
//   start bit.
// - Latency: push occurs on the clk edge of the STOP sample; rx_eff=1 the following cycle
//   (registered count). Pin edge to FSM reaction = 2 cycles (synchronizer).
// - FIFO: 2^FIFO_AW entries, wr/rd pointers FIFO_AW bits wrapping modulo depth, separate count of
//   FIFO_AW+1 bits. rx_data = mem[rd_ptr] (combinational from registered storage; 0 when empty).
// - Simultaneous events:
//   * push+pop when full: both performed, count unchanged, no overrun.
//   * push+pop when empty: pop ignored (rx_eff=0), push performed.
//   * rx_read while empty: no effect, pointers unchanged.
//   * err_clr and new error in the same cycle: flag ends set.
// - Reset mid-frame: aborts the frame, FIFO flushed, no flag set; receiver resyncs on the next
//   falling edge after rxs returns high.
// - A line held low after a framing error does not retrigger until rxs has been seen high in IDLE.
// TESTING (sim with CLKS_PER_BIT=16, FIFO_AW=2)
//   1. Send 0xA5 8N1 -> ~10 bit-times later rx_eff=1, rx_data=8'hA5, frame_err=0; pulse
//      rx_read 1 cycle -> rx_eff=0.
//   2. Send 0x01,0x80,0xFF,0x00 without reading -> rx_eff=1, pop order 01,80,FF,00;
//      then rx_eff=0.
//   3. Send 5 bytes 0x10..0x14 with no reads -> overrun=1, FIFO holds 10..13; err_clr -> overrun=0.
//   4. Send 0x3C with stop bit driven low -> frame_err=1, rx_eff stays 0; next valid 0x3D
//      received correctly.
//   5. 4-cycle low glitch on uart_rx in IDLE -> FSM returns to IDLE, rx_eff=0, no flags.
//   6. Assert reset during bit 4 of a frame, with 2 bytes queued -> next cycle rx_eff=0,
//      rx_busy=0; subsequent 0x5A received intact.
//   7. FIFO full, push and rx_read in the same cycle -> no overrun, count stays 4, order preserved.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, mid-bit sampling) feeding a small byte FIFO.
// Sticky frame/overrun flags; a set in the same cycle as err_clr wins.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_eff,
    input  logic       rx_read,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       rx_busy
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned BcW   = $clog2(CLKS_PER_BIT);
    localparam logic [BcW-1:0]     BcHalf = BcW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BcW-1:0]     BcFull = BcW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DepthC = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [BcW-1:0]     bc_q, bc_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               armed_q, armed_d;
    logic               rx_meta_q, rxs_q;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [7:0]         mem [Depth];

    logic push_req, frame_set, pop, push, full;

    // Receiver FSM; armed_q requires rxs high in IDLE before a new start can be taken.
    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q + BcW'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        armed_d   = armed_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            StIdle: begin
                bc_d = '0;
                if (rxs_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StStart;
                    armed_d = 1'b0;
                end
            end
            StStart: begin
                if (bc_q == BcHalf) begin
                    bc_d = '0;
                    if (!rxs_q) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (bc_q == BcFull) begin
                    bc_d    = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bc_q == BcFull) begin
                    bc_d    = '0;
                    state_d = StIdle;
                    if (rxs_q) begin
                        push_req = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    always_comb begin
        full     = (count_q == DepthC);
        pop      = rx_read && (count_q != '0);
        push     = push_req && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
        frame_err_d = frame_set || (frame_err_q && !err_clr);
        overrun_d   = (push_req && full && !pop) || (overrun_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bc_q        <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            armed_q     <= 1'b0;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            armed_q     <= armed_d;
            rx_meta_q   <= uart_rx;
            rxs_q       <= rx_meta_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shreg_q;
        end
    end

    assign rx_eff    = (count_q != '0);
    assign rx_data   = rx_eff ? mem[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames push expected bytes, a negedge monitor checks pops.
module tb_uart_rx_fifo;
    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_eff;
    logic       rx_read = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       err_clr = 1'b0;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_eff    (rx_eff),
        .rx_read   (rx_read),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && rx_read && rx_eff) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected nothing", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", rx_data, e);
                end
            end
        end
    end

    // Drives one 8N1 frame; optionally pulses rx_read in the cycle the stop bit is sampled.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic read_in_stop);
        logic [8:0] fr;
        fr = {b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            uart_rx = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        if (read_in_stop) begin
            repeat (CPB / 2 + 2) @(posedge clk);
            #1 rx_read = 1'b1;
            @(posedge clk);
            #1 rx_read = 1'b0;
            repeat (CPB / 2 - 3) @(posedge clk);
            #1;
        end else begin
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        int n;
        n = 0;
        while (rx_eff !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (rx_eff !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pop_wait: rx_eff got %b expected 1", rx_eff);
        end else begin
            rx_read = 1'b1;
            @(posedge clk); #1;
            rx_read = 1'b0;
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_rx_eff", rx_eff, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rx_busy", rx_busy, 0);
        repeat (10) @(posedge clk);
        #1;

        // Single byte
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        check("t1_rx_eff", rx_eff, 1);
        check("t1_frame_err", frame_err, 0);
        pop_one();
        check("t1_empty", rx_eff, 0);

        // Fill to depth, pop in order
        exp_q.push_back(8'h01); send_byte(8'h01, 1'b1, 1'b0);
        exp_q.push_back(8'h80); send_byte(8'h80, 1'b1, 1'b0);
        exp_q.push_back(8'hFF); send_byte(8'hFF, 1'b1, 1'b0);
        exp_q.push_back(8'h00); send_byte(8'h00, 1'b1, 1'b0);
        check("t2_rx_eff", rx_eff, 1);
        check("t2_overrun", overrun, 0);
        repeat (4) pop_one();
        check("t2_empty", rx_eff, 0);

        // Overrun: fifth byte dropped
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            send_byte(8'h10 + 8'(i), 1'b1, 1'b0);
        end
        check("t3_overrun", overrun, 1);
        pulse_err_clr();
        check("t3_overrun_clr", overrun, 0);
        repeat (4) pop_one();
        check("t3_empty", rx_eff, 0);

        // Framing error, line low through end of stop bit, then a good byte
        send_byte(8'h3C, 1'b0, 1'b0);
        check("t4_frame_err", frame_err, 1);
        check("t4_rx_eff", rx_eff, 0);
        exp_q.push_back(8'h3D);
        send_byte(8'h3D, 1'b1, 1'b0);
        pop_one();
        pulse_err_clr();
        check("t4_frame_clr", frame_err, 0);

        // 4-cycle glitch in IDLE
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 uart_rx = 1'b1;
        check("t5_busy_during", rx_busy, 1);
        repeat (30) @(posedge clk);
        #1;
        check("t5_busy_after", rx_busy, 0);
        check("t5_rx_eff", rx_eff, 0);
        check("t5_frame_err", frame_err, 0);
        check("t5_overrun", overrun, 0);

        // Reset mid-frame with bytes queued
        exp_q.push_back(8'h66); send_byte(8'h66, 1'b1, 1'b0);
        exp_q.push_back(8'h99); send_byte(8'h99, 1'b1, 1'b0);
        check("t6_queued", rx_eff, 1);
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 uart_rx = i[0];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rx_eff", rx_eff, 0);
        check("t6_rx_busy", rx_busy, 0);
        check("t6_rx_data", rx_data, 0);
        exp_q.delete();
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        pop_one();
        check("t6_empty", rx_eff, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            send_byte(8'h21 + 8'(i), 1'b1, 1'b0);
        end
        exp_q.push_back(8'h25);
        send_byte(8'h25, 1'b1, 1'b1);
        check("t7_overrun", overrun, 0);
        check("t7_sb_count", exp_q.size(), 4);
        repeat (4) pop_one();
        check("t7_empty", rx_eff, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
